// File: rtl/fpu_mac_sequencer_if.sv
// Handshake bundle between the MAC sequencer, its requester, the operand buffers
// and the shared FPU adder/multiplier pair.
interface fpu_mac_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH:0]   vec_len;
  logic [DATA_WIDTH-1:0] bias;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] result;

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [DATA_WIDTH-1:0] mult_a;
  logic [DATA_WIDTH-1:0] mult_b;
  logic                  mult_start;
  logic                  mult_done;
  logic [DATA_WIDTH-1:0] mult_out;

  logic [DATA_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] add_b;
  logic                  add_start;
  logic                  add_done;
  logic [DATA_WIDTH-1:0] add_out;

  // Sequencer side.
  modport master (
    input  start, vec_len, bias, a_rdata, b_rdata,
           mult_done, mult_out, add_done, add_out,
    output busy, done, error, result, rd_en, rd_addr,
           mult_a, mult_b, mult_start, add_a, add_b, add_start
  );

  // Requester, buffer and FPU side.
  modport slave (
    output start, vec_len, bias, a_rdata, b_rdata,
           mult_done, mult_out, add_done, add_out,
    input  busy, done, error, result, rd_en, rd_addr,
           mult_a, mult_b, mult_start, add_a, add_b, add_start
  );
endinterface

// File: rtl/fpu_mac_sequencer.sv
// Dot-product-plus-bias sequencer: streams operand pairs from a sync-read buffer
// through the shared FPU multiplier and adder, one element at a time.
module fpu_mac_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rstn,
  fpu_mac_sequencer_if.master bus
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]       T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]       T_ONE   = TW'(1);
  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_MUL_GO,
    S_MUL_WAIT,
    S_ADD_GO,
    S_ADD_WAIT,
    S_FIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   len;
  logic [DATA_WIDTH-1:0] acc;
  logic [TW-1:0]         timer;
  logic [ADDR_WIDTH:0]   idx_next;

  assign idx_next = idx + IDX_ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      idx            <= '0;
      len            <= '0;
      acc            <= '0;
      timer          <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      bus.result     <= '0;
      bus.rd_en      <= 1'b0;
      bus.rd_addr    <= '0;
      bus.mult_a     <= '0;
      bus.mult_b     <= '0;
      bus.mult_start <= 1'b0;
      bus.add_a      <= '0;
      bus.add_b      <= '0;
      bus.add_start  <= 1'b0;
    end else begin
      bus.rd_en      <= 1'b0;
      bus.mult_start <= 1'b0;
      bus.add_start  <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            len      <= bus.vec_len;
            acc      <= bus.bias;
            idx      <= '0;
            bus.busy <= 1'b1;
            if (bus.vec_len == '0) begin
              state <= S_FIN;
            end else begin
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= '0;
              state       <= S_READ;
            end
          end
        end

        S_READ: state <= S_LATCH;

        S_LATCH: begin
          bus.mult_a     <= bus.a_rdata;
          bus.mult_b     <= bus.b_rdata;
          bus.mult_start <= 1'b1;
          state          <= S_MUL_GO;
        end

        // add_b doubles as the product register; it stays stable until add_done.
        S_MUL_GO, S_MUL_WAIT: begin
          if (bus.mult_done) begin
            bus.add_a     <= acc;
            bus.add_b     <= bus.mult_out;
            bus.add_start <= 1'b1;
            state         <= S_ADD_GO;
          end else if (state == S_MUL_GO) begin
            timer <= '0;
            state <= S_MUL_WAIT;
          end else if (timer == T_LAST) begin
            bus.result <= acc;
            bus.done   <= 1'b1;
            bus.error  <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= S_IDLE;
          end else begin
            timer <= timer + T_ONE;
          end
        end

        S_ADD_GO, S_ADD_WAIT: begin
          if (bus.add_done) begin
            acc <= bus.add_out;
            idx <= idx_next;
            if (idx_next == len) begin
              state <= S_FIN;
            end else begin
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= idx_next[ADDR_WIDTH-1:0];
              state       <= S_READ;
            end
          end else if (state == S_ADD_GO) begin
            timer <= '0;
            state <= S_ADD_WAIT;
          end else if (timer == T_LAST) begin
            bus.result <= acc;
            bus.done   <= 1'b1;
            bus.error  <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= S_IDLE;
          end else begin
            timer <= timer + T_ONE;
          end
        end

        S_FIN: begin
          bus.result <= acc;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_mac_sequencer.sv
// Bench for fpu_mac_sequencer: behavioural sync-read buffers and a latency-randomised
// FPU stub, with results checked against a real-arithmetic dot-product model.
module tb_fpu_mac_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int          TO = 255;
  localparam int          DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fpu_mac_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fpu_mac_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  int errors = 0;
  int checks = 0;
  int mul_lat_cfg = 0;
  int add_lat_cfg = 0;
  bit mul_en = 1'b1;
  bit spur = 1'b0;
  int n_mul = 0;
  int n_add = 0;
  int n_done = 0;

  // single <-> double conversion, exact for the normal and zero values used here
  function automatic real sp2real(input logic [31:0] x);
    logic [10:0] e;
    logic [63:0] d;
    if (x[30:0] == 31'd0) return x[31] ? -0.0 : 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] int2sp(input int v);
    return real2sp(real'(v));
  endfunction

  function automatic logic [31:0] ref_dot(input int len, input logic [31:0] b);
    real acc;
    acc = sp2real(b);
    for (int i = 0; i < len; i++) acc = acc + sp2real(mem_a[i]) * sp2real(mem_b[i]);
    return real2sp(acc);
  endfunction

  // Operand buffers: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_rdata <= mem_a[bus.rd_addr];
      bus.b_rdata <= mem_b[bus.rd_addr];
    end
  end

  // FPU stub with per-op latency; may inject done pulses for the idle unit.
  int mul_cnt = 0;
  int add_cnt = 0;
  logic [31:0] mul_res, add_res;
  always @(posedge clk) begin
    bus.mult_done <= 1'b0;
    bus.add_done  <= 1'b0;
    if (bus.mult_start) begin
      mul_cnt <= !mul_en ? 0 : (mul_lat_cfg != 0) ? mul_lat_cfg : int'($urandom_range(1, 5));
      mul_res <= real2sp(sp2real(bus.mult_a) * sp2real(bus.mult_b));
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
      if (mul_cnt == 1) begin
        bus.mult_done <= 1'b1;
        bus.mult_out  <= mul_res;
      end else if (spur) begin
        bus.add_done <= 1'b1;
        bus.add_out  <= $urandom;
      end
    end
    if (bus.add_start) begin
      add_cnt <= (add_lat_cfg != 0) ? add_lat_cfg : int'($urandom_range(1, 5));
      add_res <= real2sp(sp2real(bus.add_a) + sp2real(bus.add_b));
    end else if (add_cnt > 0) begin
      add_cnt <= add_cnt - 1;
      if (add_cnt == 1) begin
        bus.add_done <= 1'b1;
        bus.add_out  <= add_res;
      end else if (spur) begin
        bus.mult_done <= 1'b1;
        bus.mult_out  <= $urandom;
      end
    end
  end

  always @(posedge clk) begin
    if (bus.mult_start === 1'b1) n_mul <= n_mul + 1;
    if (bus.add_start === 1'b1)  n_add <= n_add + 1;
    if (bus.done === 1'b1)       n_done <= n_done + 1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int len, input logic [31:0] b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.vec_len = (AW + 1)'(len);
    bus.bias    = b;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.vec_len = (AW + 1)'($urandom);
    bus.bias    = $urandom;
  endtask

  task automatic wait_done(input int budget, output int cyc, output logic got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) got = 1'b1;
    end
  endtask

  // which: 0 = mult_start, 1 = add_start
  task automatic wait_op(input int which, input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if ((which == 0 ? bus.mult_start : bus.add_start) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic do_run(input string tag, input int len, input logic [31:0] b);
    int m0, a0, cyc;
    logic got;
    logic [31:0] exp;
    exp = ref_dot(len, b);
    m0 = n_mul;
    a0 = n_add;
    start_run(len, b);
    wait_done(len * 40 + 50, cyc, got);
    check({tag, " done"}, 64'(got), 64'd1);
    check({tag, " result"}, 64'(bus.result), 64'(exp));
    check({tag, " error"}, 64'(bus.error), 64'd0);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " mul ops"}, 64'(n_mul - m0), 64'(len));
    check({tag, " add ops"}, 64'(n_add - a0), 64'(len));
  endtask

  task automatic load_s1();
    mem_a[0] = 32'h3F800000; mem_a[1] = 32'h40000000; mem_a[2] = 32'h40400000;
    mem_b[0] = 32'h3F800000; mem_b[1] = 32'h40000000; mem_b[2] = 32'h40400000;
  endtask

  initial begin
    int cyc, d0, m0, a0, len;
    logic got;
    logic [31:0] b;

    bus.start   = 1'b0;
    bus.vec_len = '0;
    bus.bias    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst error", 64'(bus.error), 64'd0);
    check("rst result", 64'(bus.result), 64'd0);
    check("rst strobes", 64'({bus.rd_en, bus.mult_start, bus.add_start}), 64'd0);
    check("rst operands", 64'({bus.mult_a, bus.add_b}), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1. 1+4+9 = 14
    load_s1();
    do_run("s1", 3, 32'h00000000);
    check("s1 value", 64'(bus.result), 64'h41600000);

    // 2. empty vector: done exactly two cycles after start
    m0 = n_mul;
    a0 = n_add;
    start_run(0, 32'h3F800000);
    check("s2 busy", 64'(bus.busy), 64'd1);
    check("s2 early done", 64'(bus.done), 64'd0);
    @(negedge clk);
    check("s2 done", 64'(bus.done), 64'd1);
    check("s2 result", 64'(bus.result), 64'h3F800000);
    check("s2 busy drop", 64'(bus.busy), 64'd0);
    check("s2 no ops", 64'((n_mul - m0) + (n_add - a0)), 64'd0);

    // 3. cancellation to zero
    mem_a[0] = 32'h40800000; mem_a[1] = 32'hBF800000;
    mem_b[0] = 32'hC0800000; mem_b[1] = 32'h3F800000;
    do_run("s3", 2, 32'h41880000);
    check("s3 value", 64'(bus.result), 64'h00000000);

    // 4. multiplier never completes: abort with the partial sum
    mul_en = 1'b0;
    b = int2sp(7);
    start_run(2, b);
    wait_op(0, 20, got);
    check("s4 mul issued", 64'(got), 64'd1);
    wait_done(TO + 20, cyc, got);
    check("s4 done", 64'(got), 64'd1);
    check("s4 error", 64'(bus.error), 64'd1);
    check("s4 result", 64'(bus.result), 64'(b));
    check("s4 latency", 64'(cyc >= TO && cyc <= TO + 2), 64'd1);
    @(negedge clk);
    check("s4 error pulse", 64'(bus.error), 64'd0);
    mul_en = 1'b1;
    repeat (5) @(negedge clk);

    // 5. start while busy is ignored
    load_s1();
    d0 = n_done;
    start_run(3, 32'h00000000);
    wait_op(0, 20, got);
    check("s5 busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b1; bus.vec_len = 9'd5; bus.bias = int2sp(99);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(200, cyc, got);
    check("s5 done", 64'(got), 64'd1);
    check("s5 result", 64'(bus.result), 64'h41600000);
    repeat (30) @(negedge clk);
    check("s5 one done", 64'(n_done - d0), 64'd1);

    // 6. reset during ADD_WAIT, then a clean run
    add_lat_cfg = 6;
    start_run(3, 32'h00000000);
    wait_op(1, 40, got);
    check("s6 add issued", 64'(got), 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("s6 busy", 64'(bus.busy), 64'd0);
    check("s6 result", 64'(bus.result), 64'd0);
    check("s6 done", 64'(bus.done), 64'd0);
    d0 = n_done;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("s6 no done", 64'(n_done - d0), 64'd0);
    add_lat_cfg = 0;
    do_run("s6 rerun", 3, 32'h00000000);
    check("s6 rerun value", 64'(bus.result), 64'h41600000);

    // random vectors with spurious done pulses on the idle unit
    spur = 1'b1;
    for (int r = 0; r < 12; r++) begin
      len = int'($urandom_range(0, 8));
      for (int i = 0; i < len; i++) begin
        mem_a[i] = int2sp(int'($urandom_range(0, 16)) - 8);
        mem_b[i] = int2sp(int'($urandom_range(0, 16)) - 8);
      end
      do_run("rand", len, int2sp(int'($urandom_range(0, 40)) - 20));
    end

    // full-depth vector
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = int2sp(int'($urandom_range(0, 16)) - 8);
      mem_b[i] = int2sp(int'($urandom_range(0, 16)) - 8);
    end
    do_run("max len", DEPTH, int2sp(3));
    spur = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
